// File: rtl/mixer_pkg.sv
// Shared types and width helpers for the time-multiplexed PSG mixer.
// Widths are derived from the channel count so the accumulator can never wrap.
package mixer_pkg;

  localparam int MASTER_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2
  } mixState_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int prodWidth(input int volW, input int envW);
    return volW + envW;
  endfunction

  // A single channel still gets one headroom bit.
  function automatic int accWidth(input int numCh, input int volW, input int envW);
    return prodWidth(volW, envW) + ((clog2(numCh) < 1) ? 1 : clog2(numCh));
  endfunction

  function automatic int idxWidth(input int numCh);
    return (clog2(numCh) < 1) ? 1 : clog2(numCh);
  endfunction

  function automatic int scaleWidth(input int accW);
    return accW + MASTER_W;
  endfunction

endpackage

// File: rtl/mixer_scale_sat.sv
// Combinational master-volume gain, right shift and saturation to the output width.
// Zero latency, no flow control; shared with the stereo mixer variant.
module mixer_scale_sat
  import mixer_pkg::*;
#(
  parameter int ACC_W     = 10,
  parameter int OUT_W     = 8,
  parameter int OUT_SHIFT = 6
) (
  input  logic [ACC_W-1:0]    acc,
  input  logic [MASTER_W-1:0] master,
  output logic [OUT_W-1:0]    satOut
);

  localparam int SP_W = scaleWidth(ACC_W);

  logic [SP_W-1:0]     prod;
  logic [SP_W-1:0]     shifted;
  logic [MASTER_W:0]   gain;

  assign gain    = {1'b0, master} + (MASTER_W + 1)'(1);
  assign prod    = SP_W'(acc) * SP_W'(gain);
  assign shifted = prod >> OUT_SHIFT;

  // Clip anything that does not fit rather than letting it wrap.
  generate
    if (SP_W > OUT_W) begin : gSat
      assign satOut = (|shifted[SP_W-1:OUT_W]) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
    end else begin : gPass
      assign satOut = OUT_W'(shifted);
    end
  endgenerate

endmodule

// File: rtl/mixer_seq.sv
// Time-multiplexed PSG mixer: snapshot on sample_tick, one channel per clock, then scale.
// Result lands NUM_CH+2 cycles after the tick; ticks arriving while busy are dropped and flagged.
module mixer_seq
  import mixer_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int VOL_W     = 4,
  parameter int ENV_W     = 4,
  parameter int OUT_W     = 8,
  parameter int OUT_SHIFT = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_tick,
  input  logic [NUM_CH-1:0]       wave,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*VOL_W-1:0] volume,
  input  logic [NUM_CH*ENV_W-1:0] env,
  input  logic [MASTER_W-1:0]     master_vol,
  output logic [OUT_W-1:0]        mixout,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int PROD_W = prodWidth(VOL_W, ENV_W);
  localparam int ACC_W  = accWidth(NUM_CH, VOL_W, ENV_W);
  localparam int IDX_W  = idxWidth(NUM_CH);

  mixState_t state, nextState;

  logic [IDX_W-1:0]    idx;
  logic [ACC_W-1:0]    acc;
  logic [NUM_CH-1:0]   snapOn;
  logic [VOL_W-1:0]    snapVol [NUM_CH];
  logic [ENV_W-1:0]    snapEnv [NUM_CH];
  logic [MASTER_W-1:0] snapMaster;

  logic                startPass;
  logic                loadOut;
  logic                lastCh;
  logic [PROD_W-1:0]   term;
  logic [OUT_W-1:0]    scaled;

  assign busy   = (state != IDLE);
  assign lastCh = (idx == IDX_W'(NUM_CH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    startPass = 1'b0;
    loadOut   = 1'b0;
    case (state)
      IDLE: begin
        if (sample_tick) begin
          startPass = 1'b1;
          nextState = ACCUM;
        end
      end
      ACCUM: begin
        if (lastCh) nextState = SCALE;
      end
      SCALE: begin
        loadOut   = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    term = '0;
    if (snapOn[idx]) term = PROD_W'(snapVol[idx]) * PROD_W'(snapEnv[idx]);
  end

  mixer_scale_sat #(
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) uScale (
    .acc   (acc),
    .master(snapMaster),
    .satOut(scaled)
  );

  // Snapshot isolates the pass from input changes until the next accepted tick.
  always_ff @(posedge clk) begin
    if (!rst && startPass) begin
      snapOn     <= wave & enable;
      snapMaster <= master_vol;
      for (int i = 0; i < NUM_CH; i++) begin
        snapVol[i] <= volume[i*VOL_W +: VOL_W];
        snapEnv[i] <= env[i*ENV_W +: ENV_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      acc       <= '0;
      mixout    <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= loadOut;
      overrun   <= sample_tick && busy;
      if (startPass) begin
        acc <= '0;
        idx <= '0;
      end else if (state == ACCUM) begin
        acc <= acc + ACC_W'(term);
        idx <= lastCh ? '0 : idx + IDX_W'(1);
      end
      if (loadOut) mixout <= scaled;
    end
  end

endmodule

// File: tb/tb_mixer_seq.sv
// Directed bench for mixer_seq: vector table of full passes plus overrun and mid-pass reset sequences.
// A second instance with OUT_SHIFT=4 exercises output saturation on the same stimulus.
module tb_mixer_seq;

  logic        clk;
  logic        rst;
  logic        sample_tick;
  logic [3:0]  wave;
  logic [3:0]  enable;
  logic [15:0] volume;
  logic [15:0] env;
  logic [3:0]  master_vol;

  logic [7:0]  mixout, mixout4;
  logic        out_valid, out_valid4;
  logic        busy, busy4;
  logic        overrun, overrun4;

  int nChk  = 0;
  int nFail = 0;

  mixer_seq #(.NUM_CH(4), .VOL_W(4), .ENV_W(4), .OUT_W(8), .OUT_SHIFT(6)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .wave(wave), .enable(enable),
    .volume(volume), .env(env), .master_vol(master_vol),
    .mixout(mixout), .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  mixer_seq #(.NUM_CH(4), .VOL_W(4), .ENV_W(4), .OUT_W(8), .OUT_SHIFT(4)) dut4 (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .wave(wave), .enable(enable),
    .volume(volume), .env(env), .master_vol(master_vol),
    .mixout(mixout4), .out_valid(out_valid4), .busy(busy4), .overrun(overrun4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0]  wave;
    logic [3:0]  en;
    logic [15:0] vol;
    logic [15:0] env;
    logic [3:0]  master;
    int          exp6;
    int          exp4;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nChk++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic scramble();
    wave       = 4'($urandom);
    enable     = 4'($urandom);
    volume     = 16'($urandom);
    env        = 16'($urandom);
    master_vol = 4'($urandom);
  endtask

  task automatic drive(input vec_t v);
    wave       = v.wave;
    enable     = v.en;
    volume     = v.vol;
    env        = v.env;
    master_vol = v.master;
  endtask

  // Called at a negedge with the FSM idle; tick is sampled at the next posedge (end of cycle T).
  task automatic runPass(input vec_t v);
    drive(v);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    scramble();
    for (int k = 1; k <= 5; k++) begin
      chk({v.name, " busy"}, int'(busy), 1);
      chk({v.name, " early out_valid"}, int'(out_valid), 0);
      chk({v.name, " overrun"}, int'(overrun), 0);
      step();
    end
    chk({v.name, " out_valid"}, int'(out_valid), 1);
    chk({v.name, " busy after"}, int'(busy), 0);
    chk({v.name, " mixout"}, int'(mixout), v.exp6);
    chk({v.name, " mixout shift4"}, int'(mixout4), v.exp4);
    step();
    chk({v.name, " out_valid drop"}, int'(out_valid), 0);
    chk({v.name, " mixout hold"}, int'(mixout), v.exp6);
  endtask

  initial begin
    int nValid;

    vecs[0] = '{"single",   4'b0001, 4'b0001, 16'h000F, 16'h000F, 4'd15, 56, 225};
    vecs[1] = '{"fullsat",  4'b1111, 4'b1111, 16'hFFFF, 16'hFFFF, 4'd15, 225, 255};
    vecs[2] = '{"master0",  4'b0001, 4'b0001, 16'h000F, 16'h000F, 4'd0, 3, 14};
    vecs[3] = '{"waveoff",  4'b0000, 4'b0001, 16'h000F, 16'h000F, 4'd0, 0, 0};
    vecs[4] = '{"mixgate",  4'b1011, 4'b0111, 16'hFFA3, 16'hFF75, 4'd7, 10, 42};
    vecs[5] = '{"mixed3",   4'b1110, 4'b1110, 16'h8FF0, 16'hFFF0, 4'd3, 35, 142};

    rst = 1'b1;
    sample_tick = 1'b0;
    scramble();
    @(posedge clk);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("reset mixout", int'(mixout), 0);
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset overrun", int'(overrun), 0);
      sample_tick = 1'($urandom);
      scramble();
      step();
    end
    rst = 1'b0;
    sample_tick = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      runPass(vecs[i]);
      step();
    end

    // Overrun: second tick at T+2 is dropped, vol0 change at T+1 must not leak in.
    drive(vecs[0]);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    volume = 16'h0000;
    step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("overrun pulse", int'(overrun), 1);
    nValid = 0;
    for (int k = 4; k <= 10; k++) begin
      step();
      if (k == 4) chk("overrun single cycle", int'(overrun), 0);
      if (k == 6) begin
        chk("overrun pass out_valid", int'(out_valid), 1);
        chk("overrun pass mixout", int'(mixout), 56);
      end
      if (out_valid) nValid++;
    end
    chk("overrun valid count", nValid, 1);

    // Reset in T+3 aborts the pass and clears the held 56.
    drive(vecs[0]);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort busy", int'(busy), 0);
    chk("abort mixout", int'(mixout), 0);
    nValid = int'(out_valid);
    step();
    nValid += int'(out_valid);
    chk("abort no out_valid", nValid, 0);
    runPass(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nChk, nFail);
    $finish;
  end

endmodule
